// File: rtl/gon_y_collector.sv
// Y-bus scan sequencer: walks a (row tag, column id) window, re-issues each request until the
// addressed PE answers, and buffers results in a first-word fall-through output FIFO.
module gon_y_collector #(
    parameter int unsigned ID_LEN     = 5,
    parameter int unsigned ROW_LEN    = 4,
    parameter int unsigned VALUE_LEN  = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ROW_LEN-1:0]      row_start,
    input  logic [ROW_LEN:0]        row_num,
    input  logic [ID_LEN:0]         col_num,
    output logic [ROW_LEN+ID_LEN:0] ready_tag,
    input  logic [VALUE_LEN:0]      enable_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VALUE_LEN-1:0]    out_data,
    output logic [ROW_LEN-1:0]      out_row,
    output logic [ID_LEN-1:0]       out_col,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned EntryW = ROW_LEN + ID_LEN + VALUE_LEN;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e              state_q;
    logic [ROW_LEN-1:0]  row_start_q;
    logic [ROW_LEN:0]    row_num_q;
    logic [ID_LEN:0]     col_num_q;
    logic [ROW_LEN:0]    r_q;
    logic [ID_LEN:0]     c_q;

    logic [EntryW-1:0]   mem [FIFO_DEPTH];
    logic [PtrW-1:0]     wptr_q;
    logic [PtrW-1:0]     rptr_q;
    logic [PtrW:0]       count_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic                ready;
    logic                push;
    logic                pop;
    logic                last_col;
    logic                last_row;
    logic [ROW_LEN-1:0]  cur_row;
    logic [EntryW-1:0]   head;

    // Full is judged on the registered count, so a same-cycle pop never re-opens ready.
    assign fifo_full  = (count_q == (PtrW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign ready      = (state_q == StIssue) && !fifo_full;
    assign push       = ready && enable_value[VALUE_LEN];
    assign pop        = !fifo_empty && out_ready;

    assign last_col = (c_q == col_num_q - (ID_LEN+1)'(1));
    assign last_row = (r_q == row_num_q - (ROW_LEN+1)'(1));
    assign cur_row  = row_start_q + r_q[ROW_LEN-1:0];

    always_comb begin
        ready_tag = '0;
        if (state_q == StIssue) begin
            ready_tag = {ready, cur_row, c_q[ID_LEN-1:0]};
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            row_start_q <= '0;
            row_num_q   <= '0;
            col_num_q   <= '0;
            r_q         <= '0;
            c_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        row_start_q <= row_start;
                        row_num_q   <= row_num;
                        col_num_q   <= col_num;
                        r_q         <= '0;
                        c_q         <= '0;
                        state_q     <= ((row_num == '0) || (col_num == '0)) ? StDone : StIssue;
                    end
                end
                StIssue: begin
                    if (push) begin
                        if (last_col) begin
                            c_q <= '0;
                            r_q <= r_q + (ROW_LEN+1)'(1);
                            if (last_row) begin
                                state_q <= StDrain;
                            end
                        end else begin
                            c_q <= c_q + (ID_LEN+1)'(1);
                        end
                    end
                end
                StDrain: begin
                    if (fifo_empty) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= {cur_row, c_q[ID_LEN-1:0], enable_value[VALUE_LEN-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head      = mem[rptr_q];
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : head[VALUE_LEN-1:0];
    assign out_col   = fifo_empty ? '0 : head[VALUE_LEN +: ID_LEN];
    assign out_row   = fifo_empty ? '0 : head[VALUE_LEN+ID_LEN +: ROW_LEN];

endmodule

// File: tb/tb_gon_y_collector.sv
// Scoreboard bench for gon_y_collector: a PE responder model predicts each tag and value,
// queues the expected entries, and the output monitor pops and compares them.
module tb_gon_y_collector;

    localparam int unsigned ID_LEN     = 5;
    localparam int unsigned ROW_LEN    = 4;
    localparam int unsigned VALUE_LEN  = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TagW       = ROW_LEN + ID_LEN + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [ROW_LEN-1:0]   row_start = '0;
    logic [ROW_LEN:0]     row_num = '0;
    logic [ID_LEN:0]      col_num = '0;
    logic [TagW-1:0]      ready_tag;
    logic [VALUE_LEN:0]   enable_value = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [VALUE_LEN-1:0] out_data;
    logic [ROW_LEN-1:0]   out_row;
    logic [ID_LEN-1:0]    out_col;
    logic                 busy;
    logic                 done;

    gon_y_collector #(
        .ID_LEN     (ID_LEN),
        .ROW_LEN    (ROW_LEN),
        .VALUE_LEN  (VALUE_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .row_start    (row_start),
        .row_num      (row_num),
        .col_num      (col_num),
        .ready_tag    (ready_tag),
        .enable_value (enable_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROW_LEN-1:0]   row;
        logic [ID_LEN-1:0]    col;
        logic [VALUE_LEN-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc, m_k, m_n, m_cn, retry_left;
    int ready_cnt, rcv_cnt, done_cnt, done_cyc, first_rdy, last_rdy;
    logic [ROW_LEN-1:0]   m_rs;
    logic                 use_fixed = 1'b0;
    logic [VALUE_LEN-1:0] fixed_val = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic step();
        exp_t                 e;
        logic [ROW_LEN-1:0]   erow;
        logic [ID_LEN-1:0]    ecol;
        logic [VALUE_LEN-1:0] v;
        int                   cn_safe;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            check_eq("out_pending", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("out_row", 64'(out_row), 64'(e.row));
                check_eq("out_col", 64'(out_col), 64'(e.col));
                check_eq("out_data", 64'(out_data), 64'(e.data));
            end
            rcv_cnt++;
        end
        // Junk with enable set while not ready: must never be captured.
        enable_value = {1'b1, 32'hBAD0_0000 | 32'(cyc)};
        if (ready_tag[TagW-1]) begin
            ready_cnt++;
            if (first_rdy < 0) first_rdy = cyc;
            last_rdy = cyc;
            cn_safe = (m_cn == 0) ? 1 : m_cn;
            erow = m_rs + ROW_LEN'(m_k / cn_safe);
            ecol = ID_LEN'(m_k % cn_safe);
            check_eq("in_window", 64'(m_k < m_n), 64'(1));
            check_eq("tag_row", 64'(ready_tag[TagW-2 -: ROW_LEN]), 64'(erow));
            check_eq("tag_col", 64'(ready_tag[ID_LEN-1:0]), 64'(ecol));
            if (retry_left > 0) begin
                retry_left--;
                enable_value = {1'b0, 32'h5555_AAAA};
            end else begin
                v = use_fixed ? fixed_val : VALUE_LEN'(int'(erow) * 16 + int'(ecol));
                enable_value = {1'b1, v};
                exp_q.push_back('{row: erow, col: ecol, data: v});
                m_k++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic new_scan(input int rs, input int rn, input int cn);
        m_rs      = ROW_LEN'(rs);
        m_n       = rn * cn;
        m_cn      = cn;
        m_k       = 0;
        ready_cnt = 0;
        rcv_cnt   = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        first_rdy = -1;
        last_rdy  = -1;
        cyc       = 0;
        row_start = ROW_LEN'(rs);
        row_num   = (ROW_LEN+1)'(rn);
        col_num   = (ID_LEN+1)'(cn);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) step();
        check_eq("done_seen", 64'(done_cnt), 64'(1));
        step();
        step();
        check_eq("done_once", 64'(done_cnt), 64'(1));
        check_eq("idle_busy", 64'(busy), 64'(0));
        check_eq("q_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tag"}, 64'(ready_tag), 64'(0));
        check_eq({tag, "_valid"}, 64'(out_valid), 64'(0));
        check_eq({tag, "_data"}, 64'(out_data), 64'(0));
        check_eq({tag, "_row"}, 64'(out_row), 64'(0));
        check_eq({tag, "_col"}, 64'(out_col), 64'(0));
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        retry_left = 0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b1;
        @(negedge clk);

        // Basic row-major order.
        new_scan(2, 2, 3);
        check_eq("basic_busy1", 64'(busy), 64'(1));
        wait_done(40);
        check_eq("basic_rcv", 64'(rcv_cnt), 64'(6));
        check_eq("basic_rdy_cnt", 64'(ready_cnt), 64'(6));
        check_eq("basic_rdy_first", 64'(first_rdy), 64'(1));
        check_eq("basic_rdy_run", 64'(last_rdy - first_rdy + 1), 64'(6));

        // Retry until the PE answers.
        use_fixed  = 1'b1;
        fixed_val  = 32'hDEAD_BEEF;
        retry_left = 5;
        new_scan(5, 1, 1);
        wait_done(40);
        check_eq("retry_rdy_cnt", 64'(ready_cnt), 64'(6));
        check_eq("retry_rcv", 64'(rcv_cnt), 64'(1));
        use_fixed = 1'b0;

        // Backpressure fills the FIFO and stalls issue.
        out_ready = 1'b0;
        new_scan(1, 1, 8);
        repeat (20) step();
        check_eq("bp_rdy_cnt", 64'(ready_cnt), 64'(FIFO_DEPTH));
        check_eq("bp_valid", 64'(out_valid), 64'(1));
        check_eq("bp_head_row", 64'(out_row), 64'(1));
        check_eq("bp_head_col", 64'(out_col), 64'(0));
        check_eq("bp_head_data", 64'(out_data), 64'(16));
        check_eq("bp_no_ready", 64'(ready_tag[TagW-1]), 64'(0));
        out_ready = 1'b1;
        wait_done(60);
        check_eq("bp_rcv", 64'(rcv_cnt), 64'(8));

        // Row tag wraps past 2^ROW_LEN - 1.
        new_scan(15, 2, 1);
        wait_done(30);
        check_eq("wrap_rcv", 64'(rcv_cnt), 64'(2));

        // Zero-size scan goes straight to DONE.
        new_scan(3, 3, 0);
        wait_done(10);
        check_eq("zero_done_cyc", 64'(done_cyc), 64'(1));
        check_eq("zero_rdy_cnt", 64'(ready_cnt), 64'(0));

        // Abort on the third element of a 2x3 scan.
        new_scan(3, 2, 3);
        for (int i = 0; i < 20 && m_k < 2; i++) step();
        check_eq("abort_reached", 64'(m_k), 64'(2));
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clk);
        check_all_zero("abort_hold");
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        new_scan(7, 1, 2);
        wait_done(30);
        check_eq("post_abort_rcv", 64'(rcv_cnt), 64'(2));

        // A start pulse mid-scan must not disturb the running scan.
        new_scan(4, 2, 2);
        step();
        step();
        row_start = 4'd9;
        row_num   = 5'd1;
        col_num   = 6'd1;
        start     = 1'b1;
        step();
        start     = 1'b0;
        wait_done(40);
        check_eq("ign_rcv", 64'(rcv_cnt), 64'(4));
        check_eq("ign_rdy_cnt", 64'(ready_cnt), 64'(4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gon_y_collector.md
# gon_y_collector

Scan sequencer and output buffer that drives the `ready_tag` port of a GON Y-bus and consumes its `enable_value` response. It walks a programmed window of (row tag, column id) pairs in row-major order and re-issues each request until the addressed PE answers. Each returned value is buffered with its coordinates in a small FWFT FIFO, and the FIFO drains over a valid/ready stream toward the global buffer.

## Interface
- `ID_LEN`, 5: column id width; matches the Y-bus.
- `ROW_LEN`, 4: row tag width; matches the Y-bus.
- `VALUE_LEN`, 32: data width.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, at least 2.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- `row_start`  in  ROW_LEN  first row tag.
- `row_num`  in  ROW_LEN+1  number of rows, 0 to 2^ROW_LEN.
- `col_num`  in  ID_LEN+1  number of columns per row, 0 to 2^ID_LEN.
- `ready_tag`  out  ROW_LEN+ID_LEN+1  {ready, row tag, column id} to the Y-bus.
- `enable_value`  in  VALUE_LEN+1  {enable, value} from the Y-bus, same-cycle response.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_data`  out  VALUE_LEN  head value.
- `out_row`  out  ROW_LEN  head row tag.
- `out_col`  out  ID_LEN  head column id.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when the scan is fully drained.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE + `start`:
  - Latch `row_start`, `row_num`, `col_num`; clear the row offset r and column c.
  - Go to ISSUE, or to DONE if `row_num`==0 or `col_num`==0.
- ISSUE:
  - ready = ~fifo_full.
  - Row tag = (row_start + r) mod 2^ROW_LEN, so the tag wraps.
  - Column id = c.
  - `ready_tag` row and id fields hold their values even when ready is 0.
- Sample:
  - `enable_value` is sampled only when ready=1.
  - If enable=1: push {row tag, c, value} and advance c. If c was col_num-1, set c=0 and increment r.
  - If the pushed element was the last (r==row_num-1 and c==col_num-1): go to DRAIN.
  - If enable=0: no push and no advance; the same tag is re-issued next cycle. Retries are unbounded.
- DRAIN: wait until the FIFO is empty, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` in any state other than IDLE is ignored; latched parameters never change mid-scan.
- FIFO (first-word fall-through):
  - `out_valid` = not empty; the head fields are stable while `out_valid`=1 and `out_ready`=0.
  - Pop on `out_valid` & `out_ready`.
- Full rule: full is evaluated before the cycle's pop. A same-cycle pop does not enable ready, so there is never an overflow.
- Push and pop in the same cycle (not full): occupancy is unchanged and order is preserved.
- `enable_value` while ready=0 is ignored.

## Timing
- All outputs reset to 0: `ready_tag`, `out_valid`, `out_data`, `out_row`, `out_col`, `busy`, `done`. The FIFO is flushed and the state is IDLE.
- Reset mid-scan aborts immediately; no `done` is produced and no partial state is retained.
- `start` sampled at edge 0: ISSUE in cycle 1, and `ready_tag` ready=1 in cycle 1 if the FIFO has room.
- Response is zero-latency: enable in the ready cycle pushes at that cycle's closing edge; `out_valid` rises the following cycle.
- Throughput with no stalls: one element per cycle.
- Minimum scan of N elements with `out_ready`=1: the last push is in cycle N; DRAIN; `done` follows 2 cycles after the FIFO empties.
- `busy` = 1 from cycle 1 through the DONE cycle inclusive.
- Zero-size scan: `start` at edge 0 leads to DONE in cycle 1 (`done`=1), then IDLE in cycle 2. `ready_tag` ready is never asserted.

## Test plan
- **Basic order:** `row_start`=2, `row_num`=2, `col_num`=3, enable always 1, value=row*16+col, `out_ready`=1.
  - Required: 6 outputs in order (2,0),(2,1),(2,2),(3,0),(3,1),(3,2) with matching data.
  - Required: ready high for 6 consecutive cycles and one `done` pulse.
- **Retry:** 1x1 scan, enable held 0 for 5 ready cycles, then 1 with value 0xDEADBEEF.
  - Required: ready is asserted 6 cycles with tag (row_start,0), and exactly one output of 0xDEADBEEF.
- **Backpressure:** `FIFO_DEPTH`=4, 1x8 scan, `out_ready`=0.
  - Required: ready drops after 4 pushes, `out_valid` stays high, and the head stays (r,0).
  - Release `out_ready`: all 8 values arrive in order, none lost or duplicated.
- **Wrap and edge sizes:**
  - `row_start`=15, `row_num`=2, `col_num`=1 with `ROW_LEN`=4: row tags 15 then 0.
  - `col_num`=0: `done` in cycle 1 and no ready.
- **Abort:** assert `rst` low during the 3rd element of a 2x3 scan.
  - Required: all outputs are 0 while in reset.
  - Then a fresh `start` completes a 1x2 scan correctly.
- **Start ignored:** pulse `start` with new parameters mid-scan.
  - Required: the original scan completes unchanged with a single `done`.
